cache_miss_controller: RTL and testbench
========================================

Name: cache_miss_controller

Overview:
- Sits between the MEM-stage data cache and main data memory.
- Stalls the pipeline on a read miss, fetches the missing word from memory over a req/ack handshake, and drives a one-cycle fill into the cache.
- Forwards every store to memory as a write-through and stalls until memory accepts it.
- Provides a watchdog timeout and two performance counters.

Parameters:
- TIMEOUT, 64: max cycles waiting for mem_ack before abort; 0 disables the watchdog.
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemReadM  in  1  MEM-stage load.
- MemWriteM  in  1  MEM-stage store.
- ALUResultM  in  32  MEM-stage byte address.
- WriteDataM  in  32  store data.
- Hit  in  1  cache hit for ALUResultM (combinational from cache).
- StallM  out  1  freeze pipeline stages up to and including MEM.
- FillEn  out  1  one-cycle cache fill strobe.
- FillAddr  out  32  word-aligned fill address.
- FillData  out  32  fill data.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  32  write data.
- mem_ack  in  1  memory completion; read data is valid in the same cycle.
- mem_rdata  in  32  read data.
- MemErr  out  1  sticky timeout flag.
- read_miss_cnt  out  CNT_WIDTH  read misses serviced.
- write_cnt  out  CNT_WIDTH  stores forwarded.

Behaviour:
- Reset (rst=0, async): state=IDLE, timeout counter=0, both perf counters=0, MemErr=0. Outputs: mem_req, mem_we, FillEn, StallM all 0; mem_addr, mem_wdata, FillAddr, FillData all 0. Reset mid-transaction abandons the request; memory must tolerate mem_req dropping without ack.
- States: IDLE, RD_REQ, FILL, WR_REQ.
- IDLE:
  - MemWriteM=1: latch aligned address and WriteDataM; go to WR_REQ; write_cnt+1. A write takes priority if MemReadM is also 1.
  - Else MemReadM=1 && Hit=0: latch aligned address; go to RD_REQ; read_miss_cnt+1.
  - StallM is combinational: high in the detecting cycle itself, i.e. when MemWriteM || (MemReadM && !Hit).
- RD_REQ:
  - mem_req=1, mem_we=0, StallM=1.
  - On mem_ack: capture mem_rdata into FillData, FillAddr=latched address; go to FILL.
- FILL:
  - FillEn=1 for exactly one cycle, StallM=1; go to IDLE.
  - In the following IDLE cycle the cache hits, StallM=0, and the load completes.
  - Minimum read-miss stall: 3 cycles with ack in the first RD_REQ cycle (detect, RD_REQ, FILL).
- WR_REQ:
  - mem_req=1, mem_we=1, mem_addr and mem_wdata held stable.
  - StallM = !mem_ack, so the store retires on the ack edge; return to IDLE.
  - The cache performs its own store update; this block never asserts FillEn for writes.
- Handshake:
  - mem_req stays high with stable address and data until the mem_ack cycle.
  - mem_req drops on the cycle after ack.
  - No new request is issued in the same cycle as an ack.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to RD_REQ or WR_REQ and increments each waiting cycle.
  - If it reaches TIMEOUT-1 without ack: set MemErr (sticky until reset) and drop mem_req.
  - Read abort: go to FILL with FillData=0.
  - Write abort: go to IDLE; StallM=0 in the abort cycle.
  - mem_ack in the timeout cycle wins; it is a normal completion.
- Counters saturate at all-ones; no wrap.
- MemReadM or MemWriteM changing while StallM=1 is ignored, because the latched values are used.

Test Plan:
- Reset with rst=0 mid-RD_REQ -> all outputs 0 immediately (async), state IDLE, counters 0; after release, a load with Hit=1 gives StallM=0 and no mem_req.
- Load 0x0000_0104 with Hit=0, memory acks after 2 cycles with 0xDEADBEEF -> mem_addr=0x104, mem_we=0; FillEn one cycle with FillAddr=0x104 and FillData=0xDEADBEEF; StallM high 4 cycles; read_miss_cnt=1.
- Store 0xCAFEF00D to 0x0000_0208, immediate ack -> mem_we=1, mem_wdata=0xCAFEF00D; StallM low on the ack cycle; FillEn never asserted; write_cnt=1.
- MemReadM=1 and MemWriteM=1 with Hit=0 -> write path only; read_miss_cnt unchanged.
- TIMEOUT=4, read miss, memory never acks -> mem_req high 4 cycles then low; MemErr=1 and stays 1; FillData=0; the next load miss still issues a new request.
- Ack arrives in the exact timeout cycle -> normal completion with FillData=mem_rdata; MemErr stays 0.

Source files
------------

// File: rtl/cache_miss_controller.sv
// Data-cache miss controller: services read misses from main memory with a
// one-cycle fill, forwards stores write-through, and guards both with a watchdog.
module cache_miss_controller #(
    parameter int TIMEOUT   = 64,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MemReadM,
    input  logic                 MemWriteM,
    input  logic [31:0]          ALUResultM,
    input  logic [31:0]          WriteDataM,
    input  logic                 Hit,
    output logic                 StallM,
    output logic                 FillEn,
    output logic [31:0]          FillAddr,
    output logic [31:0]          FillData,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rdata,
    output logic                 MemErr,
    output logic [CNT_WIDTH-1:0] read_miss_cnt,
    output logic [CNT_WIDTH-1:0] write_cnt
);

    typedef enum logic [1:0] {IDLE, RD_REQ, FILL, WR_REQ} state_t;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                 state_reg, state_next;
    logic [TW-1:0]          tmo_reg;
    logic [31:0]            addr_reg, wdata_reg;
    logic [31:0]            fill_addr_reg, fill_data_reg;
    logic                   mem_err_reg;
    logic [CNT_WIDTH-1:0]   rd_cnt_reg, wr_cnt_reg;

    logic                   tmo_hit;
    logic                   start_wr, start_rd;
    logic                   stall;
    logic [31:0]            aligned_addr;
    logic                   unused_addr_bits;

    assign aligned_addr     = {ALUResultM[31:2], 2'b00};
    assign unused_addr_bits = ^ALUResultM[1:0];

    always_comb begin
        tmo_hit    = (TIMEOUT > 0) && (tmo_reg == TMO_LAST) && !mem_ack;
        start_wr   = (state_reg == IDLE) && MemWriteM;
        start_rd   = (state_reg == IDLE) && !MemWriteM && MemReadM && !Hit;
        state_next = state_reg;
        stall      = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = MemWriteM || (MemReadM && !Hit);
                if (start_wr)
                    state_next = WR_REQ;
                else if (start_rd)
                    state_next = RD_REQ;
            end
            RD_REQ: begin
                stall = 1'b1;
                if (mem_ack || tmo_hit)
                    state_next = FILL;
            end
            FILL: begin
                stall      = 1'b1;
                state_next = IDLE;
            end
            WR_REQ: begin
                // The store retires on the ack (or abort) edge, so release the pipeline now.
                stall = !(mem_ack || tmo_hit);
                if (mem_ack || tmo_hit)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Detection is combinational from pipeline inputs; hold it quiet while in reset.
        StallM = stall && rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            tmo_reg       <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            fill_addr_reg <= '0;
            fill_data_reg <= '0;
            mem_err_reg   <= 1'b0;
            rd_cnt_reg    <= '0;
            wr_cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;

            if (start_wr) begin
                addr_reg  <= aligned_addr;
                wdata_reg <= WriteDataM;
                if (wr_cnt_reg != CNT_MAX)
                    wr_cnt_reg <= wr_cnt_reg + CNT_WIDTH'(1);
            end else if (start_rd) begin
                addr_reg <= aligned_addr;
                if (rd_cnt_reg != CNT_MAX)
                    rd_cnt_reg <= rd_cnt_reg + CNT_WIDTH'(1);
            end

            if (state_reg == IDLE)
                tmo_reg <= '0;
            else if (mem_req && !mem_ack && (tmo_reg != TMO_LAST))
                tmo_reg <= tmo_reg + TW'(1);

            if (state_reg == RD_REQ) begin
                if (mem_ack) begin
                    fill_addr_reg <= addr_reg;
                    fill_data_reg <= mem_rdata;
                end else if (tmo_hit) begin
                    fill_addr_reg <= addr_reg;
                    fill_data_reg <= '0;
                    mem_err_reg   <= 1'b1;
                end
            end

            if ((state_reg == WR_REQ) && tmo_hit)
                mem_err_reg <= 1'b1;
        end
    end

    assign mem_req       = (state_reg == RD_REQ) || (state_reg == WR_REQ);
    assign mem_we        = (state_reg == WR_REQ);
    assign mem_addr      = addr_reg;
    assign mem_wdata     = wdata_reg;
    assign FillEn        = (state_reg == FILL);
    assign FillAddr      = fill_addr_reg;
    assign FillData      = fill_data_reg;
    assign MemErr        = mem_err_reg;
    assign read_miss_cnt = rd_cnt_reg;
    assign write_cnt     = wr_cnt_reg;

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed bench for cache_miss_controller with a fill scoreboard; TIMEOUT=4.
module tb_cache_miss_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM, Hit;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM, FillEn;
    logic [31:0] FillAddr, FillData;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        MemErr;
    logic [31:0] read_miss_cnt, write_cnt;

    cache_miss_controller #(.TIMEOUT(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .Hit(Hit),
        .StallM(StallM), .FillEn(FillEn), .FillAddr(FillAddr), .FillData(FillData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .MemErr(MemErr),
        .read_miss_cnt(read_miss_cnt), .write_cnt(write_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fill_t;

    fill_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    stall_cycles;
    int    req_cycles;
    int    exp_rd = 0;
    int    exp_wr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge; fills are popped from the scoreboard here.
    task automatic half_neg();
        fill_t e;
        @(negedge clk);
        stall_cycles += int'(StallM);
        req_cycles   += int'(mem_req);
        if (FillEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("fill_unexpected", {31'b0, FillEn}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("fill_addr", FillAddr, e.addr);
                check("fill_data", FillData, e.data);
            end
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    // Load miss; memory acks in RD_REQ cycle 'delay' (>=4 means never).
    task automatic do_load(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input int delay, input logic [31:0] data);
        int n;
        fill_t e;
        n = (delay < 4) ? delay + 1 : 4;
        e.addr = exp_addr;
        e.data = (delay < 4) ? data : 32'h0;
        exp_q.push_back(e);
        exp_rd++;
        stall_cycles = 0;
        req_cycles   = 0;
        MemReadM = 1'b1; MemWriteM = 1'b0; Hit = 1'b0; ALUResultM = addr;
        mem_rdata = data;
        half_neg();
        check("ld_detect_stall", {31'b0, StallM}, 32'h1);
        to_pos();
        for (int k = 0; k < 4; k++) begin
            if (k == delay) mem_ack = 1'b1;
            half_neg();
            check("ld_req", {31'b0, mem_req}, 32'h1);
            check("ld_we", {31'b0, mem_we}, 32'h0);
            check("ld_addr", mem_addr, exp_addr);
            to_pos();
            mem_ack = 1'b0;
            if (k == delay) break;
        end
        Hit = 1'b1;
        half_neg();
        check("ld_fill_state", {31'b0, FillEn}, 32'h1);
        check("ld_req_drop", {31'b0, mem_req}, 32'h0);
        to_pos();
        half_neg();
        check("ld_release", {31'b0, StallM}, 32'h0);
        check("ld_fill_once", {31'b0, FillEn}, 32'h0);
        check("ld_stall_cycles", 32'(stall_cycles), 32'(n + 2));
        check("ld_req_cycles", 32'(req_cycles), 32'(n));
        check("ld_read_miss_cnt", read_miss_cnt, 32'(exp_rd));
        to_pos();
        MemReadM = 1'b0;
    endtask

    // Store; 'also_read' raises MemReadM too (write must win).
    task automatic do_store(input logic [31:0] addr, input logic [31:0] exp_addr,
                            input logic [31:0] data, input int delay, input logic also_read);
        int n;
        logic done;
        n = (delay < 4) ? delay + 1 : 4;
        exp_wr++;
        stall_cycles = 0;
        req_cycles   = 0;
        MemWriteM = 1'b1; MemReadM = also_read; Hit = 1'b0;
        ALUResultM = addr; WriteDataM = data;
        half_neg();
        check("st_detect_stall", {31'b0, StallM}, 32'h1);
        check("st_detect_noreq", {31'b0, mem_req}, 32'h0);
        to_pos();
        WriteDataM = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            if (k == delay) mem_ack = 1'b1;
            done = (k == delay) || (k == 3);
            half_neg();
            check("st_req", {31'b0, mem_req}, 32'h1);
            check("st_we", {31'b0, mem_we}, 32'h1);
            check("st_addr", mem_addr, exp_addr);
            check("st_wdata", mem_wdata, data);
            check("st_stall", {31'b0, StallM}, {31'b0, !done});
            to_pos();
            mem_ack = 1'b0;
            if (done) begin
                MemWriteM = 1'b0;
                MemReadM  = 1'b0;
                break;
            end
        end
        half_neg();
        check("st_req_drop", {31'b0, mem_req}, 32'h0);
        check("st_stall_cycles", 32'(stall_cycles), 32'(n));
        check("st_req_cycles", 32'(req_cycles), 32'(n));
        check("st_write_cnt", write_cnt, 32'(exp_wr));
        check("st_read_miss_cnt", read_miss_cnt, 32'(exp_rd));
        to_pos();
    endtask

    initial begin
        rst = 1'b0;
        MemReadM = 1'b0; MemWriteM = 1'b0; Hit = 1'b0;
        ALUResultM = '0; WriteDataM = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {31'b0, StallM}, 32'h0);
        check("rst_req", {31'b0, mem_req}, 32'h0);
        check("rst_fillen", {31'b0, FillEn}, 32'h0);
        check("rst_memerr", {31'b0, MemErr}, 32'h0);
        check("rst_rd_cnt", read_miss_cnt, 32'h0);
        check("rst_wr_cnt", write_cnt, 32'h0);
        rst = 1'b1;
        to_pos();

        do_load(32'h0000_0104, 32'h0000_0104, 1, 32'hDEAD_BEEF);
        do_store(32'h0000_0208, 32'h0000_0208, 32'hCAFE_F00D, 0, 1'b0);
        do_store(32'h0000_030E, 32'h0000_030C, 32'h0BAD_CAFE, 2, 1'b1);
        do_load(32'h0000_0042, 32'h0000_0040, 3, 32'h5555_AAAA);
        check("exact_tmo_memerr", {31'b0, MemErr}, 32'h0);
        do_load(32'h0000_0500, 32'h0000_0500, 9, 32'hFFFF_0001);
        check("tmo_memerr", {31'b0, MemErr}, 32'h1);
        do_load(32'h0000_0600, 32'h0000_0600, 0, 32'h1357_9BDF);
        check("memerr_sticky", {31'b0, MemErr}, 32'h1);
        do_store(32'h0000_0700, 32'h0000_0700, 32'h2468_ACE0, 9, 1'b0);
        check("memerr_after_wr_tmo", {31'b0, MemErr}, 32'h1);

        // Asynchronous reset in the middle of a read request.
        MemReadM = 1'b1; Hit = 1'b0; ALUResultM = 32'h0000_0800;
        half_neg();
        to_pos();
        half_neg();
        check("mid_req_before_rst", {31'b0, mem_req}, 32'h1);
        rst = 1'b0;
        #1;
        check("arst_req", {31'b0, mem_req}, 32'h0);
        check("arst_stall", {31'b0, StallM}, 32'h0);
        check("arst_addr", mem_addr, 32'h0);
        check("arst_filldata", FillData, 32'h0);
        check("arst_memerr", {31'b0, MemErr}, 32'h0);
        check("arst_rd_cnt", read_miss_cnt, 32'h0);
        check("arst_wr_cnt", write_cnt, 32'h0);
        MemReadM = 1'b0;
        to_pos();
        rst = 1'b1;
        MemReadM = 1'b1; Hit = 1'b1; ALUResultM = 32'h0000_0900;
        half_neg();
        check("hit_stall", {31'b0, StallM}, 32'h0);
        check("hit_req", {31'b0, mem_req}, 32'h0);
        to_pos();
        half_neg();
        check("hit_req_next", {31'b0, mem_req}, 32'h0);
        check("hit_rd_cnt", read_miss_cnt, 32'h0);
        to_pos();
        MemReadM = 1'b0;
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tb_watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
